// File: rtl/spi_chain_writer_pkg.sv
// Shared constants and state encoding for the daisy-chain serial link.
package spi_chain_writer_pkg;

  localparam int unsigned FRAME_BITS = 128;
  localparam int unsigned WORD_BITS  = 16;
  localparam int unsigned NUM_CH     = 8;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StGap,
    StDone
  } chain_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_chain_writer_timer.sv
// Loadable down-counter used to time cout phases and the latch gap.
module spi_chain_writer_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Loading N-1 makes a phase last exactly N cycles.
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/spi_chain_writer.sv
// Serialises eight 16-bit values MSB-first on dout/cout, then holds a low latch gap.
module spi_chain_writer
  import spi_chain_writer_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned LATCH_GAP   = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] v0,
  input  logic [15:0] v1,
  input  logic [15:0] v2,
  input  logic [15:0] v3,
  input  logic [15:0] v4,
  input  logic [15:0] v5,
  input  logic [15:0] v6,
  input  logic [15:0] v7,
  output logic        dout,
  output logic        cout,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TW = $clog2(max_u(HALF_PERIOD, LATCH_GAP) + 1);
  localparam logic [BIT_CNT_W-1:0] LastBit = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [TW-1:0] HalfLoad = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] GapLoad  = TW'(LATCH_GAP - 1);

  chain_state_e              state_q;
  logic [FRAME_BITS-1:0]     shift_q;
  logic [BIT_CNT_W-1:0]      bit_cnt_q;
  logic                      tmr_load;
  logic [TW-1:0]             tmr_val;
  logic                      tmr_expired;

  spi_chain_writer_timer #(
    .Width(TW)
  ) u_timer (
    .clk_i     (clock),
    .reset_i   (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expired_o (tmr_expired)
  );

  // Reload the timer on every transition into a timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tmr_load = 1'b1;
          tmr_val  = HalfLoad;
        end
      end
      StLow: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = HalfLoad;
        end
      end
      StHigh: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = (bit_cnt_q == LastBit) ? GapLoad : HalfLoad;
        end
      end
      default: ;
    endcase
  end

  // Frame FSM with registered serial outputs and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      dout      <= 1'b0;
      cout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cout <= 1'b0;
          dout <= 1'b0;
          if (start) begin
            shift_q   <= {v0, v1, v2, v3, v4, v5, v6, v7};
            bit_cnt_q <= '0;
            dout      <= v0[15];
            busy      <= 1'b1;
            state_q   <= StLow;
          end
        end
        StLow: begin
          if (tmr_expired) begin
            cout    <= 1'b1;
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (tmr_expired) begin
            cout    <= 1'b0;
            shift_q <= shift_q << 1;
            if (bit_cnt_q == LastBit) begin
              dout    <= 1'b0;
              state_q <= StGap;
            end else begin
              // Next bit appears on the same edge that drops cout.
              bit_cnt_q <= bit_cnt_q + 1'b1;
              dout      <= shift_q[FRAME_BITS-2];
              state_q   <= StLow;
            end
          end
        end
        StGap: begin
          if (tmr_expired) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_chain_writer.sv
// Directed bench: two writers (slow framing and back-to-back fast framing).
module tb_spi_chain_writer;

  localparam int unsigned A_HALF = 2;
  localparam int unsigned A_GAP  = 16;
  localparam int unsigned B_HALF = 1;
  localparam int unsigned B_GAP  = 1;
  // Offsets in posedges from the accepting edge, as seen at the following negedge.
  localparam int A_RISE_OFS = A_HALF;
  localparam int A_DONE_OFS = 256 * A_HALF + A_GAP;
  // LOW/HIGH phases + gap + DONE + one IDLE cycle per frame.
  localparam int B_PERIOD   = 256 * B_HALF + B_GAP + 2;
  localparam logic [127:0] B_EXP = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  typedef struct {
    string        name;
    logic [127:0] vin;
    logic [127:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_reset, a_start, a_dout, a_cout, a_busy, a_done;
  logic [15:0] a_v [8];
  logic        b_reset, b_start, b_dout, b_cout, b_busy, b_done;
  logic [15:0] b_v [8];

  spi_chain_writer #(.HALF_PERIOD(A_HALF), .LATCH_GAP(A_GAP)) dut_a (
    .clock(clk), .reset(a_reset), .start(a_start),
    .v0(a_v[0]), .v1(a_v[1]), .v2(a_v[2]), .v3(a_v[3]),
    .v4(a_v[4]), .v5(a_v[5]), .v6(a_v[6]), .v7(a_v[7]),
    .dout(a_dout), .cout(a_cout), .busy(a_busy), .done(a_done)
  );

  spi_chain_writer #(.HALF_PERIOD(B_HALF), .LATCH_GAP(B_GAP)) dut_b (
    .clock(clk), .reset(b_reset), .start(b_start),
    .v0(b_v[0]), .v1(b_v[1]), .v2(b_v[2]), .v3(b_v[3]),
    .v4(b_v[4]), .v5(b_v[5]), .v6(b_v[6]), .v7(b_v[7]),
    .dout(b_dout), .cout(b_cout), .busy(b_busy), .done(b_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Receiver model for writer A: shift in dout on every cout rising edge.
  logic [127:0] a_rx = '0;
  int a_rise_cnt = 0, a_done_cnt = 0, a_first_rise = -1, a_done_cyc = -1;
  logic a_cout_p = 1'b0, a_dout_p = 1'b0;
  always @(negedge clk) begin
    if (a_cout && !a_cout_p) begin
      if (a_rise_cnt == 0) a_first_rise = cyc;
      check1("a_dout_stable_at_rise", a_dout, a_dout_p);
      a_rx = {a_rx[126:0], a_dout};
      a_rise_cnt++;
    end
    if (a_done) begin
      a_done_cnt++;
      a_done_cyc = cyc;
    end
    a_cout_p = a_cout;
    a_dout_p = a_dout;
  end

  // Receiver model for writer B: every frame must match and be evenly spaced.
  logic [127:0] b_rx = '0;
  int b_rise_cnt = 0, b_done_cnt = 0, b_last_done = -1;
  logic b_cout_p = 1'b0, b_dout_p = 1'b0;
  always @(negedge clk) begin
    if (b_cout && !b_cout_p) begin
      check1("b_dout_stable_at_rise", b_dout, b_dout_p);
      b_rx = {b_rx[126:0], b_dout};
      b_rise_cnt++;
    end
    if (b_done) begin
      check128("b_frame", b_rx, B_EXP);
      check_int("b_bits", b_rise_cnt, 128);
      if (b_last_done >= 0) check_int("b_done_period", cyc - b_last_done, B_PERIOD);
      b_last_done = cyc;
      b_done_cnt++;
      b_rise_cnt = 0;
    end
    b_cout_p = b_cout;
    b_dout_p = b_dout;
  end

  task automatic frame_a(input logic [127:0] vin, output int k);
    a_rx = '0;
    a_rise_cnt = 0;
    a_done_cnt = 0;
    a_first_rise = -1;
    a_done_cyc = -1;
    for (int i = 0; i < 8; i++) a_v[i] = vin[127-16*i -: 16];
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    k = cyc;
    a_start = 1'b0;
  endtask

  task automatic wait_a_rises(input int n, input int budget);
    int t = 0;
    while (a_rise_cnt < n && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_int("a_rise_wait", int'(a_rise_cnt >= n), 1);
  endtask

  task automatic wait_a_done(input int budget);
    int t = 0;
    while (a_done_cnt == 0 && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_int("a_done_wait", int'(a_done_cnt > 0), 1);
  endtask

  task automatic finish_a(input string name, input int k, input logic [127:0] exp);
    wait_a_done(2000);
    check_int({name, "_first_rise"}, a_first_rise - k, A_RISE_OFS);
    check_int({name, "_done_lat"}, a_done_cyc - k, A_DONE_OFS);
    check_int({name, "_bits"}, a_rise_cnt, 128);
    check128({name, "_frame"}, a_rx, exp);
    @(negedge clk);
    #1;
    check1({name, "_done_one_cycle"}, a_done, 1'b0);
    check1({name, "_idle_busy"}, a_busy, 1'b0);
    check_int({name, "_done_count"}, a_done_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [3];
    int   k;
    tbl[0] = '{"t_a5c3", {16'hA5C3, 112'h0},
               128'hA5C3_0000_0000_0000_0000_0000_0000_0000};
    tbl[1] = '{"t_ramp", {16'h1111, 16'h2222, 16'h3333, 16'h4444,
                          16'h5555, 16'h6666, 16'h7777, 16'h8888},
               128'h1111_2222_3333_4444_5555_6666_7777_8888};
    tbl[2] = '{"t_mixed", 128'hFFFF_0001_8000_7FFE_DEAD_BEEF_0F0F_F0F0,
               128'hFFFF_0001_8000_7FFE_DEAD_BEEF_0F0F_F0F0};

    a_reset = 1'b1;
    b_reset = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_v[i] = '0;
      b_v[i] = B_EXP[127-16*i -: 16];
    end
    repeat (3) @(negedge clk);
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(negedge clk);
    check1("rst_dout", a_dout, 1'b0);
    check1("rst_cout", a_cout, 1'b0);
    check1("rst_busy", a_busy, 1'b0);
    check1("rst_done", a_done, 1'b0);

    // Writer B free-runs with start held high for the rest of the test.
    b_start = 1'b1;

    for (int i = 0; i < 3; i++) begin
      frame_a(tbl[i].vin, k);
      check1({tbl[i].name, "_busy"}, a_busy, 1'b1);
      check1({tbl[i].name, "_first_bit"}, a_dout, tbl[i].exp[127]);
      finish_a(tbl[i].name, k, tbl[i].exp);
      if (i == 1) begin
        for (int w = 0; w < 8; w++)
          check_int($sformatf("loop_word%0d", w), int'(a_rx[127-16*w -: 16]),
                    'h1111 * (w + 1));
      end
    end

    // start pulses mid-frame are ignored.
    frame_a(tbl[2].vin, k);
    wait_a_rises(40, 2000);
    @(negedge clk);
    a_start = 1'b1;
    repeat (3) @(negedge clk);
    a_start = 1'b0;
    finish_a("busy_start", k, tbl[2].exp);
    repeat (20) @(negedge clk);
    #1;
    check1("busy_start_no_refire", a_busy, 1'b0);
    check_int("busy_start_single_done", a_done_cnt, 1);

    // Inputs scrambled every cycle after capture.
    frame_a(tbl[1].vin, k);
    for (int t = 0; t < 2000 && a_done_cnt == 0; t++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) a_v[i] = 16'($urandom);
    end
    finish_a("v_change", k, tbl[1].exp);

    // Reset mid-frame abandons it; the next frame is clean.
    frame_a(tbl[2].vin, k);
    wait_a_rises(60, 2000);
    @(negedge clk);
    a_reset = 1'b1;
    @(negedge clk);
    #1;
    check1("midrst_cout", a_cout, 1'b0);
    check1("midrst_dout", a_dout, 1'b0);
    check1("midrst_busy", a_busy, 1'b0);
    check1("midrst_done", a_done, 1'b0);
    a_reset = 1'b0;
    frame_a(tbl[0].vin, k);
    finish_a("after_rst", k, tbl[0].exp);

    check_int("b_frames_seen", int'(b_done_cnt >= 3), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
